// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: default geometry,
// ABI register indices and a helper for slicing packed per-port buses.
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    // ABI register names
    localparam int ZERO = 0;
    localparam int RA   = 1;
    localparam int SP   = 2;
    localparam int GP   = 3;
    localparam int TP   = 4;
    localparam int T0   = 5;
    localparam int T1   = 6;
    localparam int T2   = 7;
    localparam int S0   = 8;
    localparam int S1   = 9;
    localparam int A0   = 10;
    localparam int A1   = 11;
    localparam int A2   = 12;
    localparam int A3   = 13;
    localparam int A4   = 14;
    localparam int A5   = 15;
    localparam int A6   = 16;
    localparam int A7   = 17;
    localparam int S2   = 18;
    localparam int S3   = 19;
    localparam int S4   = 20;
    localparam int S5   = 21;
    localparam int S6   = 22;
    localparam int S7   = 23;
    localparam int S8   = 24;
    localparam int S9   = 25;
    localparam int S10  = 26;
    localparam int S11  = 27;
    localparam int T3   = 28;
    localparam int T4   = 29;
    localparam int T5   = 30;
    localparam int T6   = 31;

    // Low bit of port 'port' inside a packed bus of 'width'-bit fields.
    function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for decode hazard stalls. Writes clear a register's busy
// bit, allocation sets it; when both hit the same register in one cycle the
// allocation wins since it names a newer producer. Bit 0 is never busy.
// Per-port rd_busy_o reports the next-state bit of the addressed register.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [NRD-1:0]    rd_en_i,
    input  logic [NRD*AW-1:0] rd_addr_i,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    input  logic              alloc_en_i,
    input  logic [AW-1:0]     alloc_addr_i,
    output logic [NREGS-1:0]  busy_vec_o,
    output logic [NRD-1:0]    rd_busy_o
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [NRD-1:0]   rd_busy_q, rd_busy_d;

    // Next-state busy vector: clears first, then the allocation set overrides.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j]) begin
                busy_d[wr_addr_i[slice_lo(j, AW) +: AW]] = 1'b0;
            end
        end
        if (alloc_en_i) begin
            busy_d[alloc_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Per-port busy lookup on the next-state vector; held when the port is idle.
    always_comb begin
        rd_busy_d = rd_busy_q;
        for (int i = 0; i < NRD; i++) begin
            if (rd_en_i[i]) begin
                rd_busy_d[i] = busy_d[rd_addr_i[slice_lo(i, AW) +: AW]];
            end
        end
    end

    // Scoreboard and registered lookup state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q    <= '0;
            rd_busy_q <= '0;
        end else begin
            busy_q    <= busy_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign busy_vec_o = busy_q;
    assign rd_busy_o  = rd_busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with registered reads,
// hardwired x0 and a busy scoreboard. Macro REGFILE_BYPASS_EN selects
// write-first forwarding on a same-cycle read/write match; without it the
// read returns the old value and rd_conflict flags the port so decode re-reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEFAULT,
    parameter  int NREGS = NREGS_DEFAULT,
    parameter  int NRD   = 2,
    parameter  int NWR   = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_valid,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    output logic [NREGS-1:0]    busy_vec
`ifndef REGFILE_BYPASS_EN
    ,
    output logic [NRD-1:0]      rd_conflict
`endif
);

    logic [XLEN-1:0] regs_q    [NREGS];
    logic [AW-1:0]   rd_addr_a [NRD];
    logic [AW-1:0]   wr_addr_a [NWR];
    logic [XLEN-1:0] wr_data_a [NWR];
    logic [XLEN-1:0] rd_word   [NRD];
    logic [XLEN-1:0] rd_data_q [NRD];
    logic [XLEN-1:0] rd_data_d [NRD];
    logic [NRD-1:0]  rd_valid_q;
    logic [NRD-1:0]  hit;
`ifdef REGFILE_BYPASS_EN
    logic [XLEN-1:0] fwd       [NRD];
`else
    logic [NRD-1:0]  rd_conflict_q, rd_conflict_d;
`endif

    for (genvar i = 0; i < NRD; i++) begin : g_rd_ports
        assign rd_addr_a[i] = rd_addr[slice_lo(i, AW) +: AW];
        assign rd_data[slice_lo(i, XLEN) +: XLEN] = rd_data_q[i];
    end

    for (genvar j = 0; j < NWR; j++) begin : g_wr_ports
        assign wr_addr_a[j] = wr_addr[slice_lo(j, AW) +: AW];
        assign wr_data_a[j] = wr_data[slice_lo(j, XLEN) +: XLEN];
    end

    // Storage: later write ports override earlier ones on the same address.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr_a[j] != '0)) begin
                    regs_q[wr_addr_a[j]] <= wr_data_a[j];
                end
            end
        end
    end

    // Read mux plus same-cycle write match detection per read port.
    always_comb begin
        hit = '0;
`ifndef REGFILE_BYPASS_EN
        rd_conflict_d = '0;
`endif
        for (int i = 0; i < NRD; i++) begin
            rd_word[i]   = (rd_addr_a[i] == '0) ? '0 : regs_q[rd_addr_a[i]];
            rd_data_d[i] = rd_data_q[i];
`ifdef REGFILE_BYPASS_EN
            fwd[i] = '0;
`endif
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr_a[j] == rd_addr_a[i]) && (rd_addr_a[i] != '0)) begin
                    hit[i] = 1'b1;
`ifdef REGFILE_BYPASS_EN
                    fwd[i] = wr_data_a[j];
`endif
                end
            end
`ifdef REGFILE_BYPASS_EN
            if (hit[i]) begin
                rd_word[i] = fwd[i];
            end
`else
            rd_conflict_d[i] = rd_en[i] & hit[i];
`endif
            if (rd_en[i]) begin
                rd_data_d[i] = rd_word[i];
            end
        end
    end

    // Registered read outputs; idle ports keep their last data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NRD; i++) begin
                rd_data_q[i] <= '0;
            end
            rd_valid_q <= '0;
`ifndef REGFILE_BYPASS_EN
            rd_conflict_q <= '0;
`endif
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en;
`ifndef REGFILE_BYPASS_EN
            rd_conflict_q <= rd_conflict_d;
`endif
        end
    end

    assign rd_valid = rd_valid_q;
`ifndef REGFILE_BYPASS_EN
    assign rd_conflict = rd_conflict_q;
`endif

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk_i        (clk),
        .reset_i      (reset),
        .rd_en_i      (rd_en),
        .rd_addr_i    (rd_addr),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .alloc_en_i   (alloc_en),
        .alloc_addr_i (alloc_addr),
        .busy_vec_o   (busy_vec),
        .rd_busy_o    (rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp (two read ports, two write ports).
// Builds with or without REGFILE_BYPASS_EN.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_valid;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic [NREGS-1:0]    busy_vec;
`ifndef REGFILE_BYPASS_EN
    logic [NRD-1:0]      rd_conflict;
`endif

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .busy_vec   (busy_vec)
`ifndef REGFILE_BYPASS_EN
        ,
        .rd_conflict(rd_conflict)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural state and expected outputs.
    logic [XLEN-1:0]  model_regs [NREGS];
    bit               model_busy [NREGS];
    logic [XLEN-1:0]  exp_q[$];
    logic [XLEN-1:0]  last_data [NRD];
    logic [NRD-1:0]   exp_valid;
    logic [NRD-1:0]   exp_rd_busy;
    logic [NRD-1:0]   exp_conf;
    logic [NREGS-1:0] exp_busy_vec;

    // ---------------- driver tasks ----------------
    task automatic idle();
        reset      = 1'b0;
        rd_en      = '0;
        rd_addr    = '0;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = a[AW-1:0];
    endtask

    task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = a[AW-1:0];
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic set_alloc(input int a);
        alloc_en   = 1'b1;
        alloc_addr = a[AW-1:0];
    endtask

    // Computes what the architecture should show after the next edge for the
    // inputs now applied, advances one clock, and leaves outputs settled.
    task automatic do_cycle();
        logic [XLEN-1:0] new_regs [NREGS];
        bit              new_busy [NREGS];
        logic [XLEN-1:0] d;
        int              ra;
        int              wa;
        bit              written;
        exp_q.delete();
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                new_regs[r] = '0;
                new_busy[r] = 1'b0;
            end
            exp_valid   = '0;
            exp_rd_busy = '0;
            exp_conf    = '0;
            for (int i = 0; i < NRD; i++) last_data[i] = '0;
        end else begin
            new_regs = model_regs;
            new_busy = model_busy;
            for (int j = 0; j < NWR; j++) begin
                wa = int'(wr_addr[j*AW +: AW]);
                if (wr_en[j] && wa != 0) begin
                    new_regs[wa] = wr_data[j*XLEN +: XLEN];
                    new_busy[wa] = 1'b0;
                end
            end
            if (alloc_en && alloc_addr != '0) new_busy[alloc_addr] = 1'b1;
            for (int i = 0; i < NRD; i++) begin
                exp_valid[i] = rd_en[i];
                exp_conf[i]  = 1'b0;
                if (rd_en[i]) begin
                    ra = int'(rd_addr[i*AW +: AW]);
                    written = 1'b0;
                    for (int j = 0; j < NWR; j++) begin
                        if (wr_en[j] && ra != 0 && int'(wr_addr[j*AW +: AW]) == ra) written = 1'b1;
                    end
`ifdef REGFILE_BYPASS_EN
                    d = new_regs[ra];
`else
                    d = model_regs[ra];
                    exp_conf[i] = written;
`endif
                    exp_q.push_back(d);
                    last_data[i]   = d;
                    exp_rd_busy[i] = new_busy[ra];
                end
            end
        end
        @(posedge clk);
        model_regs = new_regs;
        model_busy = new_busy;
        for (int r = 0; r < NREGS; r++) exp_busy_vec[r] = new_busy[r];
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        reset = 1'b1;
        do_cycle();
        n_checks++;
        if (busy_vec !== '0) begin
            n_fail++; $display("FAIL reset_busy_vec: got %h expected 0", busy_vec);
        end
        n_checks++;
        if (rd_valid !== '0 || rd_busy !== '0 || rd_data !== '0) begin
            n_fail++; $display("FAIL reset_outputs: valid %b busy %b data %h expected all 0", rd_valid, rd_busy, rd_data);
        end
        for (int a = 0; a < NREGS; a++) begin
            idle();
            set_rd(0, a);
            set_rd(1, NREGS - 1 - a);
            do_cycle();
            n_checks++;
            if (rd_data !== '0 || rd_valid !== 2'b11 || rd_busy !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_read_x%0d: data %h valid %b busy %b expected 0/11/00", a, rd_data, rd_valid, rd_busy);
            end
        end
    endtask

    task automatic test_write_read();
        idle(); set_wr(0, T0, 32'hDEAD_BEEF); do_cycle();
        idle(); set_rd(1, T0); do_cycle();
        n_checks++;
        if (rd_data[XLEN +: XLEN] !== 32'hDEAD_BEEF || rd_valid[1] !== 1'b1) begin
            n_fail++; $display("FAIL read_x5: got %h valid %b expected deadbeef 1", rd_data[XLEN +: XLEN], rd_valid[1]);
        end
        idle(); set_wr(0, ZERO, 32'h0000_1234); do_cycle();
        idle(); set_rd(0, ZERO); do_cycle();
        n_checks++;
        if (rd_data[0 +: XLEN] !== 32'h0) begin
            n_fail++; $display("FAIL read_x0: got %h expected 0", rd_data[0 +: XLEN]);
        end
    endtask

    task automatic test_forward();
        idle(); set_wr(0, T2, 32'hA5A5_A5A5); set_rd(0, T2); do_cycle();
        n_checks++;
        if (rd_valid[0] !== 1'b1) begin
            n_fail++; $display("FAIL fwd_valid: got %b expected 1", rd_valid[0]);
        end
`ifdef REGFILE_BYPASS_EN
        n_checks++;
        if (rd_data[0 +: XLEN] !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL fwd_data: got %h expected a5a5a5a5", rd_data[0 +: XLEN]);
        end
`else
        n_checks++;
        if (rd_data[0 +: XLEN] !== 32'h0 || rd_conflict[0] !== 1'b1) begin
            n_fail++; $display("FAIL fwd_old: data %h conflict %b expected 0 1", rd_data[0 +: XLEN], rd_conflict[0]);
        end
`endif
        idle(); set_rd(0, T2); do_cycle();
        n_checks++;
        if (rd_data[0 +: XLEN] !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL fwd_after: got %h expected a5a5a5a5", rd_data[0 +: XLEN]);
        end
`ifndef REGFILE_BYPASS_EN
        n_checks++;
        if (rd_conflict[0] !== 1'b0) begin
            n_fail++; $display("FAIL fwd_conflict_clear: got %b expected 0", rd_conflict[0]);
        end
`endif
    endtask

    task automatic test_multi_write();
        idle(); set_wr(0, S1, 32'h11); set_wr(1, S1, 32'h22); do_cycle();
        idle(); set_rd(0, S1); set_rd(1, S1); do_cycle();
        n_checks++;
        if (rd_data !== {32'h22, 32'h22}) begin
            n_fail++; $display("FAIL multi_write_x9: got %h expected 22 on both ports", rd_data);
        end
    endtask

    task automatic test_scoreboard();
        idle(); set_alloc(A0); do_cycle();
        n_checks++;
        if (busy_vec[A0] !== 1'b1) begin
            n_fail++; $display("FAIL sb_alloc: got %b expected 1", busy_vec[A0]);
        end
        idle(); set_rd(0, A0); do_cycle();
        n_checks++;
        if (rd_busy[0] !== 1'b1) begin
            n_fail++; $display("FAIL sb_rd_busy: got %b expected 1", rd_busy[0]);
        end
        idle(); set_wr(0, A0, 32'h55); do_cycle();
        n_checks++;
        if (busy_vec[A0] !== 1'b0) begin
            n_fail++; $display("FAIL sb_clear: got %b expected 0", busy_vec[A0]);
        end
        idle(); set_alloc(A0); do_cycle();
        idle(); set_wr(1, A0, 32'h66); set_rd(0, A0); do_cycle();
        n_checks++;
        if (rd_busy[0] !== 1'b0 || busy_vec[A0] !== 1'b0) begin
            n_fail++; $display("FAIL sb_write_read: rd_busy %b busy %b expected 0 0", rd_busy[0], busy_vec[A0]);
        end
        idle(); set_alloc(A0); set_wr(0, A0, 32'h77); set_rd(1, A0); do_cycle();
        n_checks++;
        if (busy_vec[A0] !== 1'b1 || rd_busy[1] !== 1'b1) begin
            n_fail++; $display("FAIL sb_set_wins: busy %b rd_busy %b expected 1 1", busy_vec[A0], rd_busy[1]);
        end
        idle(); set_alloc(ZERO); do_cycle();
        n_checks++;
        if (busy_vec[0] !== 1'b0 || busy_vec[A0] !== 1'b1) begin
            n_fail++; $display("FAIL sb_alloc_x0: bit0 %b bit10 %b expected 0 1", busy_vec[0], busy_vec[A0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] e;
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int i = 0; i < NRD; i++) begin
                if ($urandom_range(0, 3) != 0)
                    set_rd(i, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1));
            end
            for (int j = 0; j < NWR; j++) begin
                if ($urandom_range(0, 1) != 0)
                    set_wr(j, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1), $urandom());
            end
            if ($urandom_range(0, 2) == 0) set_alloc($urandom_range(0, 7));
            reset = ($urandom_range(0, 39) == 0);
            do_cycle();
            for (int i = 0; i < NRD; i++) begin
                n_checks++;
                if (exp_valid[i]) begin
                    e = exp_q.pop_front();
                    if (rd_data[i*XLEN +: XLEN] !== e || rd_busy[i] !== exp_rd_busy[i]) begin
                        n_fail++;
                        $display("FAIL rand_read c%0d p%0d: data %h busy %b expected %h %b", c, i, rd_data[i*XLEN +: XLEN], rd_busy[i], e, exp_rd_busy[i]);
                    end
                end else if (rd_data[i*XLEN +: XLEN] !== last_data[i]) begin
                    n_fail++;
                    $display("FAIL rand_hold c%0d p%0d: data %h expected %h", c, i, rd_data[i*XLEN +: XLEN], last_data[i]);
                end
            end
            n_checks++;
            if (rd_valid !== exp_valid || busy_vec !== exp_busy_vec) begin
                n_fail++;
                $display("FAIL rand_state c%0d: valid %b busy_vec %h expected %b %h", c, rd_valid, busy_vec, exp_valid, exp_busy_vec);
            end
`ifndef REGFILE_BYPASS_EN
            n_checks++;
            if (rd_conflict !== exp_conf) begin
                n_fail++; $display("FAIL rand_conflict c%0d: got %b expected %b", c, rd_conflict, exp_conf);
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        idle(); set_wr(0, GP, 32'hFF); set_alloc(GP); set_rd(0, GP); reset = 1'b1; do_cycle();
        n_checks++;
        if (rd_valid !== '0 || busy_vec !== '0 || rd_data !== '0) begin
            n_fail++; $display("FAIL reset_mid: valid %b busy_vec %h data %h expected all 0", rd_valid, busy_vec, rd_data);
        end
        idle(); set_rd(0, GP); do_cycle();
        n_checks++;
        if (rd_data[0 +: XLEN] !== 32'h0 || rd_valid[0] !== 1'b1 || rd_busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_x3: data %h valid %b busy %b expected 0 1 0", rd_data[0 +: XLEN], rd_valid[0], rd_busy[0]);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int r = 0; r < NREGS; r++) begin
            model_regs[r] = '0;
            model_busy[r] = 1'b0;
        end
        idle();
        reset = 1'b1;
        test_reset();
        test_write_read();
        test_forward();
        test_multi_write();
        test_scoreboard();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
